// File: rtl/fifo_pkg.sv
// Shared types and Gray/binary helpers for the asynchronous FIFO pointer controllers.
// Helpers work on a fixed maximum width; callers pass a mask for their real width.
package fifo_pkg;

  localparam int PTR_MAX_W  = 17;
  localparam int DROP_CNT_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // All-ones mask covering the low w bits (w = PTR_MAX_W yields all ones).
  function automatic ptr_max_t width_mask(input int w);
    return (ptr_max_t'(1) << w) - ptr_max_t'(1);
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t b, input ptr_max_t mask);
    ptr_max_t bm;
    bm = b & mask;
    return (bm >> 1) ^ bm;
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g, input ptr_max_t mask);
    ptr_max_t gm;
    ptr_max_t b;
    gm = g & mask;
    b  = gm;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_cnt.sv
// Binary + Gray pointer register pair with increment enable; shared by the
// write-side full controller and the read-side empty controller.
module fifo_gray_cnt
  import fifo_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic [W-1:0] binnext,
  output logic [W-1:0] graynext
);

  localparam ptr_max_t MASK = width_mask(W);

  // Wrap from all-ones back to zero falls out of the modulo-2**W add.
  assign binnext  = bin + W'(inc);
  assign graynext = W'(bin2gray(PTR_MAX_W'(binnext), MASK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= binnext;
      gray <= graynext;
    end
  end

endmodule

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-domain pointer, full, almost-full and fill-level controller for the async FIFO.
// Optional drop statistics (woverflow, wdrop_cnt) are built when FIFO_WOVF_STATS_EN is defined.
module fifo_wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDRSIZE:0]     wq2_rptr,
  output logic [ADDRSIZE:0]     wptr,
  output logic [ADDRSIZE-1:0]   waddr,
  output logic                  wen,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDRSIZE:0]     wlevel
`ifdef FIFO_WOVF_STATS_EN
  ,
  output logic                  woverflow,
  output logic [DROP_CNT_W-1:0] wdrop_cnt
`endif
);

  localparam int       PW           = ADDRSIZE + 1;
  localparam int       DEPTH        = 1 << ADDRSIZE;
  localparam ptr_max_t MASK         = width_mask(PW);
  localparam logic [ADDRSIZE:0] AFULL_THRESH = PW'(DEPTH - AFULL_MARGIN);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic              wfull_next;
  logic              walmost_full_next;
  logic              unused_wbin_msb;

  // Handshake: winc is a write request held by the producer; wen is its
  // acceptance. A request is consumed on the wclk edge where wen is high;
  // a request seen while wfull is high is dropped, never stalled or queued.
  assign wen = winc & ~wfull;

  fifo_gray_cnt #(
    .W (PW)
  ) u_wptr_cnt (
    .clk      (wclk),
    .rst      (wrst),
    .inc      (wen),
    .bin      (wbin),
    .gray     (wptr),
    .binnext  (wbinnext),
    .graynext (wgraynext)
  );

  assign waddr           = wbin[ADDRSIZE-1:0];
  assign unused_wbin_msb = wbin[ADDRSIZE];

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray form that means the top two bits inverted, rest equal.
  assign wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE -: 2], wq2_rptr[ADDRSIZE-2:0]});

  // The synchronised read pointer lags the real one, so this level can only
  // over-estimate occupancy.
  assign rbin_s            = PW'(gray2bin(PTR_MAX_W'(wq2_rptr), MASK));
  assign level_next        = wbinnext - rbin_s;
  assign walmost_full_next = (level_next >= AFULL_THRESH);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wlevel       <= level_next;
    end
  end

`ifdef FIFO_WOVF_STATS_EN
  logic wdrop;

  assign wdrop = winc & wfull;

  // Sticky overflow flag and a drop counter that saturates instead of wrapping.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      woverflow <= 1'b0;
      wdrop_cnt <= '0;
    end else if (wdrop) begin
      woverflow <= 1'b1;
      if (wdrop_cnt != {DROP_CNT_W{1'b1}}) begin
        wdrop_cnt <= wdrop_cnt + DROP_CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Scoreboard bench for fifo_wptr_full_ctrl at ADDRSIZE=4, AFULL_MARGIN=2.
// Covers the drop statistics ports too when FIFO_WOVF_STATS_EN is defined.
module tb_fifo_wptr_full_ctrl;

  localparam int A = 4;
  localparam int CW = 17;
`ifdef FIFO_WOVF_STATS_EN
  localparam int EW = CW + 17;
`else
  localparam int EW = CW;
`endif

  logic         wclk = 1'b0;
  logic         wrst = 1'b1;
  logic         winc = 1'b0;
  logic [A:0]   wq2_rptr = '0;
  logic [A:0]   wptr;
  logic [A-1:0] waddr;
  logic         wen;
  logic         wfull;
  logic         walmost_full;
  logic [A:0]   wlevel;
`ifdef FIFO_WOVF_STATS_EN
  logic         woverflow;
  logic [15:0]  wdrop_cnt;
`endif

  fifo_wptr_full_ctrl #(
    .ADDRSIZE     (A),
    .AFULL_MARGIN (2)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wptr         (wptr),
    .waddr        (waddr),
    .wen          (wen),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel)
`ifdef FIFO_WOVF_STATS_EN
    ,
    .woverflow    (woverflow),
    .wdrop_cnt    (wdrop_cnt)
`endif
  );

  // clock / reset
  always #5 wclk = ~wclk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_vec = 0;
  int            n_bad = 0;

  // reference model: true write/read counts, not pointer arithmetic
  int   m_wr   = 0;
  int   m_rd   = 0;
  int   m_lvl  = 0;
  int   m_drop = 0;
  logic m_full = 1'b0;
  logic m_alm  = 1'b0;
  logic m_ovf  = 1'b0;

  function automatic logic [A:0] gray5(input int n);
    logic [A:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CW-1:0] pack_core(input logic wen_v, input logic [4:0] p,
                                              input logic [3:0] a, input logic f,
                                              input logic af, input logic [4:0] lv);
    return {wen_v, p, a, f, af, lv};
  endfunction

  // driver: inputs change just after a rising edge; the expectation pushed
  // describes what the monitor should see before the next rising edge
  task automatic step(input logic winc_v, input logic rd_v, input logic use_lit,
                      input logic [EW-1:0] lit, input string tag);
    logic          wen_m;
    logic [CW-1:0] core;
    logic [EW-1:0] e;
    @(posedge wclk);
    #1;
    wen_m = winc_v & ~m_full;
    core  = pack_core(wen_m, gray5(m_wr), 4'(m_wr % 16), m_full, m_alm, 5'(m_lvl));
`ifdef FIFO_WOVF_STATS_EN
    e = {m_ovf, 16'(m_drop), core};
`else
    e = core;
`endif
    exp_q.push_back(use_lit ? lit : e);
    tag_q.push_back(tag);
    winc = winc_v;
    if (rd_v) m_rd++;
    wq2_rptr = gray5(m_rd);
    if (winc_v && m_full) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
    if (wen_m) m_wr++;
    m_lvl  = m_wr - m_rd;
    m_full = (m_lvl == 16);
    m_alm  = (m_lvl >= 14);
  endtask

  // reset asserted between edges; the check lands before any further rising edge
  task automatic mid_reset();
    @(posedge wclk);
    #3;
    winc = 1'b0;
    wrst = 1'b1;
    wq2_rptr = '0;
    m_wr = 0; m_rd = 0; m_lvl = 0; m_drop = 0;
    m_full = 1'b0; m_alm = 1'b0; m_ovf = 1'b0;
    exp_q.push_back('0);
    tag_q.push_back("async_reset");
    @(posedge wclk);
    #1;
    wrst = 1'b0;
  endtask

  // monitor: compares whatever the DUT presents against the oldest expectation
  always @(negedge wclk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    string         t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
`ifdef FIFO_WOVF_STATS_EN
      act = {woverflow, wdrop_cnt, wen, wptr, waddr, wfull, walmost_full, wlevel};
`else
      act = {wen, wptr, waddr, wfull, walmost_full, wlevel};
`endif
      n_vec++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (stats,wen,wptr,waddr,wfull,walmost_full,wlevel)",
                 t, act, e);
      end
    end
  end

  initial begin
    logic [EW-1:0] lit;
    // power-on reset
    exp_q.push_back('0);
    tag_q.push_back("por_reset");
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b0;

    // five writes, confirm pointer moved, then reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, "pre_reset_write");
    step(1'b0, 1'b0, 1'b1, EW'(pack_core(1'b0, 5'b00111, 4'd5, 1'b0, 1'b0, 5'd5)), "after_5_writes");
    mid_reset();

    // fill from empty with the read pointer parked at zero
    for (int k = 1; k <= 16; k++) begin
      if (k == 15)
        step(1'b1, 1'b0, 1'b1, EW'(pack_core(1'b1, 5'b01001, 4'd14, 1'b0, 1'b1, 5'd14)), "afull_at_14");
      else
        step(1'b1, 1'b0, 1'b0, '0, "fill");
    end

    // three writes while full are dropped
    step(1'b1, 1'b0, 1'b1, EW'(pack_core(1'b0, 5'b11000, 4'd0, 1'b1, 1'b1, 5'd16)), "full_at_16");
    step(1'b1, 1'b0, 1'b0, '0, "overflow");
    step(1'b1, 1'b0, 1'b0, '0, "overflow");

    // one read seen by the write side releases full
`ifdef FIFO_WOVF_STATS_EN
    lit = {1'b1, 16'd3, pack_core(1'b0, 5'b11000, 4'd0, 1'b1, 1'b1, 5'd16)};
`else
    lit = pack_core(1'b0, 5'b11000, 4'd0, 1'b1, 1'b1, 5'd16);
`endif
    step(1'b0, 1'b1, 1'b1, lit, "overflow_held");
`ifdef FIFO_WOVF_STATS_EN
    lit = {1'b1, 16'd3, pack_core(1'b0, 5'b11000, 4'd0, 1'b0, 1'b1, 5'd15)};
`else
    lit = pack_core(1'b0, 5'b11000, 4'd0, 1'b0, 1'b1, 5'd15);
`endif
    step(1'b0, 1'b0, 1'b1, lit, "drain_release");

    // drain down to a mid level
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, '0, "drain");

    // interleaved traffic across the pointer wrap, level kept in 4..8
    for (int i = 0; i < 40; i++) begin
      step(logic'(m_lvl < 8), logic'(m_lvl > 4 && (i % 2) == 0), 1'b0, '0, "wrap");
    end

    // climb to 15, then write in the same cycle the read pointer advances
    for (int i = 0; i < 16 && m_lvl < 15; i++) step(1'b1, 1'b0, 1'b0, '0, "refill");
    step(1'b1, 1'b1, 1'b0, '0, "simul_accept");
    step(1'b0, 1'b0, 1'b0, '0, "simul_result");
    step(1'b0, 1'b0, 1'b0, '0, "idle");

    repeat (3) @(negedge wclk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
